// File: rtl/runtime_store_table_pkg.sv
// Shared FSM state type, AXI constants and burst sizing helper for the runtime store table.
package runtime_store_table_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int DEF_AXI_DATA_WIDTH = 512;
    localparam int DEF_DWIDTH         = 32;
    localparam int BPB                = DEF_AXI_DATA_WIDTH / 8;
    localparam int WPB                = DEF_AXI_DATA_WIDTH / DEF_DWIDTH;
    localparam logic [31:0] BOUNDARY_4K = 32'd4096;

    // Beats in the next burst: capped by the burst limit, the beats left, and the 4 KiB page end.
    function automatic logic [31:0] calc_burst_len(
        input logic [31:0] rem_beats,
        input logic [11:0] addr_lo,
        input logic [31:0] beat_bytes,
        input logic [31:0] max_burst
    );
        logic [31:0] to_boundary;
        logic [31:0] len;
        to_boundary = (BOUNDARY_4K - {20'd0, addr_lo}) / beat_bytes;
        len = max_burst;
        if (rem_beats < len) len = rem_beats;
        if (to_boundary < len) len = to_boundary;
        return len;
    endfunction

endpackage

// File: rtl/store_table_col_ram.sv
// One column capture table: word-wide write port, beat-wide (WPB words) registered read port.
module store_table_col_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    parameter int WPB    = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(WPB),
    localparam int BW    = AW - LW
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DWIDTH-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [BW-1:0]           rd_beat,
    output logic [WPB*DWIDTH-1:0]   rd_data
);

    logic [WPB-1:0][DWIDTH-1:0] mem [DEPTH/WPB];
    logic [WPB*DWIDTH-1:0]      rd_data_q;

    // Read register only updates on rd_en so a stalled beat stays stable under concurrent capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:LW]][wr_addr[LW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_beat];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/runtime_store_table.sv
// Per-column CGRA result capture tables drained to memory through an AXI4 write master.
// Optional RUNTIME_STORE_TABLE_CAP_WRAP_EN: capture into a full table overwrites the oldest entry.
module runtime_store_table
    import runtime_store_table_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
    parameter int NUM_COL            = 2,
    parameter int DWIDTH             = DEF_DWIDTH,
    parameter int DEPTH              = 256,
    parameter int C_MAX_BURST        = 16,
    localparam int CW                = $clog2(DEPTH) + 1,
    localparam int COLW              = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic [NUM_COL-1:0]              cap_en,
    input  logic [NUM_COL*DWIDTH-1:0]       cap_data,
    input  logic [NUM_COL-1:0]              cap_clear,
    output logic [NUM_COL*CW-1:0]           cap_count,
    output logic [NUM_COL-1:0]              cap_full,
    input  logic                            ctrl_start,
    input  logic [COLW-1:0]                 ctrl_col,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [CW-1:0]                   ctrl_num_words,
    output logic                            ctrl_busy,
    output logic                            ctrl_done,
    output logic                            ctrl_error,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic [1:0]                      m_axi_bresp
);

    localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int WORDS_PB   = C_M_AXI_DATA_WIDTH / DWIDTH;
    localparam int WORD_BYTES = DWIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int BW         = AW - $clog2(WORDS_PB);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WPB_C   = CW'(WORDS_PB);

    state_e                           state_q, state_d;
    logic [COLW-1:0]                  col_q, col_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [CW-1:0]                    rem_q, rem_d;
    logic [BW-1:0]                    rd_beat_q, rd_beat_d;
    logic [7:0]                       beat_cnt_q, beat_cnt_d;
    logic [7:0]                       awlen_q, awlen_d;
    logic                             wv_q, wv_d;
    logic                             err_q, err_d;

    logic [CW-1:0]                    count_q [NUM_COL];
    logic [CW-1:0]                    count_d [NUM_COL];
    logic [AW-1:0]                    wr_ptr_q [NUM_COL];
    logic [AW-1:0]                    wr_ptr_d [NUM_COL];
    logic [NUM_COL-1:0]               ram_wr_en;
    logic [AW-1:0]                    ram_wr_addr [NUM_COL];
    logic [WORDS_PB*DWIDTH-1:0]       ram_rd_data [NUM_COL];

    logic                             rd_en;
    logic [CW-1:0]                    start_words;
    logic [CW-1:0]                    rem_beats;
    logic [CW-1:0]                    lane_words;
    logic [8:0]                       aw_len_c;
    logic [C_M_AXI_DATA_WIDTH-1:0]    beat_data;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]  beat_strb;

    for (genvar g = 0; g < NUM_COL; g++) begin : g_col
        store_table_col_ram #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH),
            .WPB    (WORDS_PB)
        ) u_ram (
            .clk     (aclk),
            .wr_en   (ram_wr_en[g]),
            .wr_addr (ram_wr_addr[g]),
            .wr_data (cap_data[g*DWIDTH +: DWIDTH]),
            .rd_en   (rd_en),
            .rd_beat (rd_beat_q),
            .rd_data (ram_rd_data[g])
        );
        assign cap_count[g*CW +: CW] = count_q[g];
        assign cap_full[g]           = (count_q[g] == DEPTH_C);
    end

    // Clear wins over a same-cycle capture, except for the column currently being drained.
    always_comb begin
        for (int c = 0; c < NUM_COL; c++) begin
            count_d[c]     = count_q[c];
            wr_ptr_d[c]    = wr_ptr_q[c];
            ram_wr_en[c]   = 1'b0;
            ram_wr_addr[c] = wr_ptr_q[c];
            if (cap_clear[c] && !((state_q != ST_IDLE) && (col_q == COLW'(c)))) begin
                ram_wr_addr[c] = '0;
                ram_wr_en[c]   = cap_en[c];
                count_d[c]     = cap_en[c] ? CW'(1) : '0;
                wr_ptr_d[c]    = cap_en[c] ? AW'(1) : '0;
            end else if (cap_en[c]) begin
                if (count_q[c] != DEPTH_C) begin
                    ram_wr_en[c] = 1'b1;
                    count_d[c]   = count_q[c] + CW'(1);
                    wr_ptr_d[c]  = wr_ptr_q[c] + AW'(1);
                end
`ifdef RUNTIME_STORE_TABLE_CAP_WRAP_EN
                else begin
                    ram_wr_en[c] = 1'b1;
                    wr_ptr_d[c]  = wr_ptr_q[c] + AW'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int c = 0; c < NUM_COL; c++) begin
                count_q[c]  <= '0;
                wr_ptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_COL; c++) begin
                count_q[c]  <= count_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
            end
        end
    end

    assign start_words = (ctrl_num_words < count_q[ctrl_col]) ? ctrl_num_words : count_q[ctrl_col];
    assign rem_beats   = CW'((32'(rem_q) + 32'(WORDS_PB) - 32'd1) / 32'(WORDS_PB));
    assign lane_words  = (rem_q > WPB_C) ? WPB_C : rem_q;
    assign aw_len_c    = 9'(calc_burst_len(32'(rem_beats), addr_q[11:0],
                                           32'(BEAT_BYTES), 32'(C_MAX_BURST)));

    // Lanes beyond the words left in the drain are zeroed and left unstrobed.
    always_comb begin
        beat_data = '0;
        beat_strb = '0;
        for (int k = 0; k < WORDS_PB; k++) begin
            if (CW'(k) < lane_words) begin
                beat_data[k*DWIDTH +: DWIDTH]         = ram_rd_data[col_q][k*DWIDTH +: DWIDTH];
                beat_strb[k*WORD_BYTES +: WORD_BYTES] = '1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_beat_d  = rd_beat_q;
        beat_cnt_d = beat_cnt_q;
        awlen_d    = awlen_q;
        wv_d       = wv_q;
        err_d      = err_q;
        rd_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    col_d     = ctrl_col;
                    addr_d    = ctrl_addr_offset;
                    rem_d     = start_words;
                    rd_beat_d = '0;
                    err_d     = 1'b0;
                    state_d   = (start_words == '0) ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    awlen_d    = 8'(aw_len_c - 9'd1);
                    beat_cnt_d = '0;
                    addr_d     = addr_q + C_M_AXI_ADDR_WIDTH'(32'(aw_len_c) * 32'(BEAT_BYTES));
                    wv_d       = 1'b0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                // Each beat takes a fetch cycle into the RAM read register, then is offered on W.
                if (!wv_q) begin
                    rd_en = 1'b1;
                    wv_d  = 1'b1;
                end else if (m_axi_wready) begin
                    wv_d       = 1'b0;
                    rd_beat_d  = rd_beat_q + BW'(1);
                    rem_d      = rem_q - lane_words;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == awlen_q) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = (rem_q == '0) ? ST_DONE : ST_AW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_beat_q  <= '0;
            beat_cnt_q <= '0;
            awlen_q    <= '0;
            wv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_beat_q  <= rd_beat_d;
            beat_cnt_q <= beat_cnt_d;
            awlen_q    <= awlen_d;
            wv_q       <= wv_d;
            err_q      <= err_d;
        end
    end

    assign ctrl_busy     = (state_q != ST_IDLE);
    assign ctrl_done     = (state_q == ST_DONE);
    assign ctrl_error    = err_q;
    assign m_axi_awvalid = (state_q == ST_AW);
    assign m_axi_awaddr  = m_axi_awvalid ? addr_q : '0;
    assign m_axi_awlen   = m_axi_awvalid ? 8'(aw_len_c - 9'd1) : '0;
    assign m_axi_wvalid  = (state_q == ST_W) && wv_q;
    assign m_axi_wdata   = m_axi_wvalid ? beat_data : '0;
    assign m_axi_wstrb   = m_axi_wvalid ? beat_strb : '0;
    assign m_axi_wlast   = m_axi_wvalid && (beat_cnt_q == awlen_q);
    assign m_axi_bready  = (state_q == ST_B);

endmodule

// File: tb/tb_runtime_store_table.sv
// Directed bench for runtime_store_table: capture, packing, 4 KiB split, stalls, errors, overflow.
module tb_runtime_store_table;

    logic          aclk;
    logic          areset_n;
    logic [1:0]    cap_en;
    logic [63:0]   cap_data;
    logic [1:0]    cap_clear;
    logic [17:0]   cap_count;
    logic [1:0]    cap_full;
    logic          ctrl_start;
    logic [0:0]    ctrl_col;
    logic [63:0]   ctrl_addr_offset;
    logic [8:0]    ctrl_num_words;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          ctrl_error;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [63:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [511:0]  m_axi_wdata;
    logic [63:0]   m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [1:0]    m_axi_bresp;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [63:0]   aw_addr_log[$];
    logic [7:0]    aw_len_log[$];
    logic [511:0]  w_data_log[$];
    logic [63:0]   w_strb_log[$];
    logic          w_last_log[$];
    int            done_cnt, done_cyc, aw_cyc, stall_viol;

    runtime_store_table dut (
        .aclk             (aclk),
        .areset_n         (areset_n),
        .cap_en           (cap_en),
        .cap_data         (cap_data),
        .cap_clear        (cap_clear),
        .cap_count        (cap_count),
        .cap_full         (cap_full),
        .ctrl_start       (ctrl_start),
        .ctrl_col         (ctrl_col),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_num_words   (ctrl_num_words),
        .ctrl_busy        (ctrl_busy),
        .ctrl_done        (ctrl_done),
        .ctrl_error       (ctrl_error),
        .m_axi_awvalid    (m_axi_awvalid),
        .m_axi_awready    (m_axi_awready),
        .m_axi_awaddr     (m_axi_awaddr),
        .m_axi_awlen      (m_axi_awlen),
        .m_axi_wvalid     (m_axi_wvalid),
        .m_axi_wready     (m_axi_wready),
        .m_axi_wdata      (m_axi_wdata),
        .m_axi_wstrb      (m_axi_wstrb),
        .m_axi_wlast      (m_axi_wlast),
        .m_axi_bvalid     (m_axi_bvalid),
        .m_axi_bready     (m_axi_bready),
        .m_axi_bresp      (m_axi_bresp)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Expected content of column 0 after 256 fills plus one overflow word.
    function automatic logic [31:0] col0_word(input int i);
`ifdef RUNTIME_STORE_TABLE_CAP_WRAP_EN
        if (i == 0) return 32'hDEAD0101;
`endif
        return 32'hA0000000 + 32'(i);
    endfunction

    task automatic cap_push(input int col, input logic [31:0] d, input logic clr);
        cap_en   = '0;
        cap_clear = '0;
        cap_en[col]   = 1'b1;
        cap_clear[col] = clr;
        cap_data[col*32 +: 32] = d;
        @(negedge aclk);
        cap_en    = '0;
        cap_clear = '0;
    endtask

    // Acts as the AXI slave for one drain, logging AW/W traffic and W stability under stall.
    task automatic run_drain(input logic [0:0] col, input logic [63:0] addr, input logic [8:0] num,
                             input bit stall, input logic [1:0] resp);
        int pend_b, post;
        logic pv, pr, plast;
        logic [511:0] pdata;
        logic [63:0]  pstrb;
        aw_addr_log.delete(); aw_len_log.delete();
        w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
        done_cnt = 0; done_cyc = -1; aw_cyc = -1; stall_viol = 0;
        pend_b = 0; post = 0; pv = 1'b0; pr = 1'b0; plast = 1'b0; pdata = '0; pstrb = '0;
        ctrl_col = col; ctrl_addr_offset = addr; ctrl_num_words = num; ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (ctrl_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cnt > 0) begin
                post++;
                if (post > 3) break;
            end
            m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi_awvalid && aw_cyc < 0) aw_cyc = cyc;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(m_axi_awlen);
            end
            m_axi_wready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (pv && !pr) begin
                if (!m_axi_wvalid || m_axi_wdata !== pdata || m_axi_wstrb !== pstrb || m_axi_wlast !== plast)
                    stall_viol++;
            end
            pv = m_axi_wvalid; pr = m_axi_wready;
            pdata = m_axi_wdata; pstrb = m_axi_wstrb; plast = m_axi_wlast;
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_log.push_back(m_axi_wdata);
                w_strb_log.push_back(m_axi_wstrb);
                w_last_log.push_back(m_axi_wlast);
                if (m_axi_wlast) pend_b++;
            end
            m_axi_bvalid = (pend_b > 0) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            m_axi_bresp  = resp;
            if (m_axi_bvalid && m_axi_bready) pend_b--;
            @(negedge aclk);
        end
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        vec_cnt++; if (cap_count !== 18'd0) begin err_cnt++; $display("[TB] FAIL reset_count: got %h want 0", cap_count); end
        vec_cnt++; if (cap_full !== 2'b00) begin err_cnt++; $display("[TB] FAIL reset_full: got %b want 00", cap_full); end
        vec_cnt++; if ({ctrl_busy, ctrl_done, ctrl_error} !== 3'b000) begin err_cnt++; $display("[TB] FAIL reset_ctrl: got %b want 000", {ctrl_busy, ctrl_done, ctrl_error}); end
        vec_cnt++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000) begin err_cnt++; $display("[TB] FAIL reset_axi: got %b want 000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single_beat();
        logic [511:0] exp_d;
        exp_d = {384'd0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        cap_push(0, 32'h11111111, 1'b0);
        cap_push(0, 32'h22222222, 1'b0);
        cap_push(0, 32'h33333333, 1'b0);
        cap_push(0, 32'h44444444, 1'b0);
        vec_cnt++; if (cap_count[8:0] !== 9'd4) begin err_cnt++; $display("[TB] FAIL single_count: got %0d want 4", cap_count[8:0]); end
        run_drain(1'b0, 64'h0, 9'd4, 1'b0, 2'b00);
        vec_cnt++; if (aw_cyc !== 0) begin err_cnt++; $display("[TB] FAIL single_aw_latency: got %0d want 0", aw_cyc); end
        vec_cnt++; if (aw_addr_log.size() !== 1 || aw_len_log.size() !== 1) begin err_cnt++; $display("[TB] FAIL single_aw_count: got %0d want 1", aw_addr_log.size()); end
        vec_cnt++; if (w_data_log.size() !== 1) begin err_cnt++; $display("[TB] FAIL single_beats: got %0d want 1", w_data_log.size()); end
        if (aw_addr_log.size() >= 1 && w_data_log.size() >= 1) begin
            vec_cnt++; if (aw_addr_log[0] !== 64'h0 || aw_len_log[0] !== 8'd0) begin err_cnt++; $display("[TB] FAIL single_aw: got %h/%0d want 0/0", aw_addr_log[0], aw_len_log[0]); end
            vec_cnt++; if (w_data_log[0] !== exp_d) begin err_cnt++; $display("[TB] FAIL single_wdata: got %h want %h", w_data_log[0], exp_d); end
            vec_cnt++; if (w_strb_log[0] !== 64'h000000000000FFFF) begin err_cnt++; $display("[TB] FAIL single_wstrb: got %h want FFFF", w_strb_log[0]); end
            vec_cnt++; if (w_last_log[0] !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_wlast: got %b want 1", w_last_log[0]); end
        end
        vec_cnt++; if (done_cnt !== 1 || ctrl_error !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_done: got %0d/%b want 1/0", done_cnt, ctrl_error); end
    endtask

    task automatic test_partial_beat();
        logic [511:0] exp_d;
        exp_d = '0;
        for (int i = 0; i < 40; i++) cap_push(1, 32'hC1000000 + 32'(i), 1'b0);
        for (int k = 0; k < 8; k++) exp_d[k*32 +: 32] = 32'hC1000000 + 32'(32 + k);
        run_drain(1'b1, 64'h1000, 9'd40, 1'b0, 2'b00);
        vec_cnt++; if (aw_addr_log.size() !== 1 || w_data_log.size() !== 3) begin err_cnt++; $display("[TB] FAIL partial_counts: got %0d/%0d want 1/3", aw_addr_log.size(), w_data_log.size()); end
        if (aw_addr_log.size() >= 1 && w_data_log.size() >= 3) begin
            vec_cnt++; if (aw_addr_log[0] !== 64'h1000 || aw_len_log[0] !== 8'd2) begin err_cnt++; $display("[TB] FAIL partial_aw: got %h/%0d want 1000/2", aw_addr_log[0], aw_len_log[0]); end
            vec_cnt++; if (w_strb_log[2] !== 64'h00000000FFFFFFFF) begin err_cnt++; $display("[TB] FAIL partial_wstrb: got %h want FFFFFFFF", w_strb_log[2]); end
            vec_cnt++; if (w_data_log[2] !== exp_d) begin err_cnt++; $display("[TB] FAIL partial_wdata: got %h want %h", w_data_log[2], exp_d); end
            vec_cnt++; if (w_data_log[0][31:0] !== 32'hC1000000 || w_data_log[1][511:480] !== 32'hC100001F) begin err_cnt++; $display("[TB] FAIL partial_full_beats: got %h/%h", w_data_log[0][31:0], w_data_log[1][511:480]); end
            vec_cnt++; if ({w_last_log[2], w_last_log[1], w_last_log[0]} !== 3'b100) begin err_cnt++; $display("[TB] FAIL partial_wlast: got %b want 100", {w_last_log[2], w_last_log[1], w_last_log[0]}); end
        end
        vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("[TB] FAIL partial_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_overflow_4k();
        int bad;
        logic [511:0] dw;
        cap_push(0, 32'hA0000000, 1'b1);
        for (int i = 1; i < 256; i++) cap_push(0, 32'hA0000000 + 32'(i), 1'b0);
        vec_cnt++; if (cap_count[8:0] !== 9'd256 || cap_full[0] !== 1'b1) begin err_cnt++; $display("[TB] FAIL fill_256: got %0d/%b want 256/1", cap_count[8:0], cap_full[0]); end
        cap_push(0, 32'hDEAD0101, 1'b0);
        vec_cnt++; if (cap_count[8:0] !== 9'd256 || cap_full[0] !== 1'b1) begin err_cnt++; $display("[TB] FAIL fill_257: got %0d/%b want 256/1", cap_count[8:0], cap_full[0]); end
        run_drain(1'b0, 64'hF80, 9'd256, 1'b0, 2'b00);
        vec_cnt++; if (aw_addr_log.size() !== 2) begin err_cnt++; $display("[TB] FAIL split_aw_count: got %0d want 2", aw_addr_log.size()); end
        if (aw_addr_log.size() >= 2) begin
            vec_cnt++; if (aw_addr_log[0] !== 64'hF80 || aw_len_log[0] !== 8'd1) begin err_cnt++; $display("[TB] FAIL split_aw0: got %h/%0d want F80/1", aw_addr_log[0], aw_len_log[0]); end
            vec_cnt++; if (aw_addr_log[1] !== 64'h1000 || aw_len_log[1] !== 8'd13) begin err_cnt++; $display("[TB] FAIL split_aw1: got %h/%0d want 1000/13", aw_addr_log[1], aw_len_log[1]); end
        end
        vec_cnt++; if (w_data_log.size() !== 16 || done_cnt !== 1) begin err_cnt++; $display("[TB] FAIL split_beats_done: got %0d/%0d want 16/1", w_data_log.size(), done_cnt); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) begin
            dw = w_data_log[b];
            for (int k = 0; k < 16; k++) if (dw[k*32 +: 32] !== col0_word(b*16 + k)) bad++;
        end
        vec_cnt++; if (bad !== 0) begin err_cnt++; $display("[TB] FAIL split_image: got %0d bad words want 0", bad); end
    endtask

    task automatic test_stalls();
        int bad;
        logic [511:0] dw;
        run_drain(1'b0, 64'h2000, 9'd256, 1'b1, 2'b00);
        vec_cnt++; if (aw_addr_log.size() !== 1 || w_data_log.size() !== 16) begin err_cnt++; $display("[TB] FAIL stall_counts: got %0d/%0d want 1/16", aw_addr_log.size(), w_data_log.size()); end
        if (aw_addr_log.size() >= 1) begin
            vec_cnt++; if (aw_addr_log[0] !== 64'h2000 || aw_len_log[0] !== 8'd15) begin err_cnt++; $display("[TB] FAIL stall_aw: got %h/%0d want 2000/15", aw_addr_log[0], aw_len_log[0]); end
        end
        vec_cnt++; if (stall_viol !== 0) begin err_cnt++; $display("[TB] FAIL stall_stability: got %0d changes want 0", stall_viol); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) begin
            dw = w_data_log[b];
            for (int k = 0; k < 16; k++) if (dw[k*32 +: 32] !== col0_word(b*16 + k)) bad++;
        end
        vec_cnt++; if (bad !== 0) begin err_cnt++; $display("[TB] FAIL stall_image: got %0d bad words want 0", bad); end
        vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("[TB] FAIL stall_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_bresp_error();
        run_drain(1'b1, 64'h4000, 9'd4, 1'b0, 2'b10);
        vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("[TB] FAIL err_done: got %0d want 1", done_cnt); end
        vec_cnt++; if (ctrl_error !== 1'b1) begin err_cnt++; $display("[TB] FAIL err_sticky: got %b want 1", ctrl_error); end
    endtask

    task automatic test_zero_words();
        run_drain(1'b1, 64'h5000, 9'd0, 1'b0, 2'b00);
        vec_cnt++; if (done_cyc !== 0 || done_cnt !== 1) begin err_cnt++; $display("[TB] FAIL zero_done: got cyc %0d cnt %0d want 0/1", done_cyc, done_cnt); end
        vec_cnt++; if (aw_cyc !== -1) begin err_cnt++; $display("[TB] FAIL zero_no_aw: got %0d want -1", aw_cyc); end
        vec_cnt++; if (ctrl_error !== 1'b0) begin err_cnt++; $display("[TB] FAIL zero_err_clear: got %b want 0", ctrl_error); end
    endtask

    task automatic test_clear_priority();
        logic [511:0] exp_d;
        exp_d = {480'd0, 32'h5A5A5A5A};
        cap_push(1, 32'h5A5A5A5A, 1'b1);
        vec_cnt++; if (cap_count[17:9] !== 9'd1) begin err_cnt++; $display("[TB] FAIL clear_count: got %0d want 1", cap_count[17:9]); end
        run_drain(1'b1, 64'h3000, 9'd5, 1'b0, 2'b00);
        vec_cnt++; if (w_data_log.size() !== 1) begin err_cnt++; $display("[TB] FAIL clear_beats: got %0d want 1", w_data_log.size()); end
        if (w_data_log.size() >= 1) begin
            vec_cnt++; if (w_data_log[0] !== exp_d || w_strb_log[0] !== 64'hF) begin err_cnt++; $display("[TB] FAIL clear_beat: got %h/%h want %h/F", w_data_log[0], w_strb_log[0], exp_d); end
        end
    endtask

    initial begin
        areset_n = 1'b0;
        cap_en = '0; cap_data = '0; cap_clear = '0;
        ctrl_start = 1'b0; ctrl_col = '0; ctrl_addr_offset = '0; ctrl_num_words = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        test_reset();
        test_single_beat();
        test_partial_beat();
        test_overflow_4k();
        test_stalls();
        test_bresp_error();
        test_zero_words();
        test_clear_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
